// File: rtl/mnk_game.sv
// mnk_game: two-player N x N board referee, K marks in a line to win.
// Define MOVE_TIMEOUT_EN to add a per-turn move timer of TIMEOUT cycles.
module mnk_game #(
  parameter int N = 3,
  parameter int K = 3,
  parameter int O_FIRST = 1,
  parameter int TIMEOUT = 1000,
  localparam int CELLS = N * N,
  localparam int PW = $clog2(CELLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              playX,
  input  logic              playO,
  input  logic [PW-1:0]     playerX_position,
  input  logic [PW-1:0]     playerO_position,
  output logic [2*CELLS-1:0] board,
  output logic [1:0]        who,
  output logic              turn,
  output logic              game_over,
  output logic              illegal
);

  typedef enum logic [1:0] {
    X_TURN,
    O_TURN,
    CHECK,
    OVER
  } state_t;

  state_t state, state_n;

  logic [2*CELLS-1:0] board_n;
  logic [1:0] who_n;
  logic turn_n;
  logic illegal_n;

  logic x_q, x_q2, o_q, o_q2;
  logic [PW-1:0] xpos_q, opos_q;

  logic req, accept, win, full;
  logic [1:0] code;
  logic [PW-1:0] pos;

  function automatic logic [1:0] cell_at(
    input logic [2*CELLS-1:0] b,
    input int r,
    input int s
  );
    if (r < 0 || r >= N || s < 0 || s >= N)
      return 2'b00;
    return b[2*(r*N+s) +: 2];
  endfunction

  // Every cell is tried as the start of all four line directions;
  // runs that leave the board read as empty and so never match.
  function automatic logic line_win(
    input logic [2*CELLS-1:0] b,
    input logic [1:0] c
  );
    logic h, v, d, a, w;
    w = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int s = 0; s < N; s++) begin
        h = 1'b1;
        v = 1'b1;
        d = 1'b1;
        a = 1'b1;
        for (int i = 0; i < K; i++) begin
          h &= (cell_at(b, r, s + i) == c);
          v &= (cell_at(b, r + i, s) == c);
          d &= (cell_at(b, r + i, s + i) == c);
          a &= (cell_at(b, r + i, s - i) == c);
        end
        w |= h | v | d | a;
      end
    end
    return w;
  endfunction

`ifdef MOVE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic expire;
  assign expire = (int'(cnt) == TIMEOUT - 1);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT;
`endif

  assign game_over = |who;

  always_comb begin
    full = 1'b1;
    for (int i = 0; i < CELLS; i++)
      if (board[2*i +: 2] == 2'b00)
        full = 1'b0;
  end

  always_comb begin
    code = turn ? 2'b10 : 2'b01;
    req = turn ? (o_q & ~o_q2) : (x_q & ~x_q2);
    pos = turn ? opos_q : xpos_q;
    accept = req && (int'(pos) < CELLS) &&
      (cell_at(board, int'(pos) / N, int'(pos) % N) == 2'b00);
  end

  assign win = line_win(board, code);

  always_comb begin
    state_n = state;
    board_n = board;
    who_n = who;
    turn_n = turn;
    illegal_n = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    cnt_n = cnt;
`endif
    unique case (state)
      X_TURN, O_TURN: begin
        if (accept) begin
          board_n[2*int'(pos) +: 2] = code;
          state_n = CHECK;
`ifdef MOVE_TIMEOUT_EN
          cnt_n = '0;
`endif
        end else begin
          illegal_n = req;
`ifdef MOVE_TIMEOUT_EN
          if (expire) begin
            who_n = turn ? 2'b01 : 2'b10;
            state_n = OVER;
          end else begin
            cnt_n = cnt + 1'b1;
          end
`endif
        end
      end
      CHECK: begin
        if (win) begin
          who_n = code;
          state_n = OVER;
        end else if (full) begin
          who_n = 2'b11;
          state_n = OVER;
        end else begin
          turn_n = ~turn;
          state_n = turn ? X_TURN : O_TURN;
        end
      end
      OVER: begin
        state_n = OVER;
      end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (O_FIRST != 0) ? O_TURN : X_TURN;
      board <= '0;
      who <= 2'b00;
      turn <= (O_FIRST != 0);
      illegal <= 1'b0;
      x_q <= 1'b0;
      x_q2 <= 1'b0;
      o_q <= 1'b0;
      o_q2 <= 1'b0;
      xpos_q <= '0;
      opos_q <= '0;
`ifdef MOVE_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      state <= state_n;
      board <= board_n;
      who <= who_n;
      turn <= turn_n;
      illegal <= illegal_n;
      x_q <= playX;
      x_q2 <= x_q;
      o_q <= playO;
      o_q2 <= o_q;
      xpos_q <= playerX_position;
      opos_q <= playerO_position;
`ifdef MOVE_TIMEOUT_EN
      cnt <= cnt_n;
`endif
    end
  end

endmodule
